// File: rtl/rv32i_dmem_responder_pkg.sv
// Shared FSM encoding, default geometry and the load lane-shift helper for the data-memory responder.
// Pure definitions: no latency and no backpressure of their own.
package rv32i_dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_DEPTH_WORDS = 1024;
  localparam logic [31:0] DEF_ADDR_BASE   = 32'h0000_1000;
  localparam int unsigned DEF_WAIT_STATES = 1;
  localparam int unsigned LANE_SHIFT_W    = 5;

  // Right-align the addressed byte lane so the core can sign/zero extend from bit 0.
  function automatic logic [31:0] lane_align(input logic [31:0] word, input logic [1:0] lane);
    logic [LANE_SHIFT_W-1:0] sh;
    sh = {lane, 3'b000};
    return word >> sh;
  endfunction

endpackage

// File: rtl/rv32i_dmem_array.sv
// Four byte-wide synchronous RAM banks sharing one index, per-bank write enable, registered read.
// One-cycle read latency; no backpressure, the caller issues at most one access per cycle.
module rv32i_dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       we,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (we[b]) mem[idx] <= wdata[8*b +: 8];
      if (re)    q        <= mem[idx];
    end

    assign rdata[8*b +: 8] = q;
  end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder: one request in flight, ack WAIT_STATES+1 cycles after accept, lane-aligned loads.
// stall is held from the cycle after accept through the ack cycle; inputs are ignored while it is high.
module rv32i_dmem_responder
  import rv32i_dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask,
  output logic [31:0] rd_data,
  output logic        ack,
  output logic        err,
  output logic        stall
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        wr_q;

  logic             accept;
  logic             enter_resp;
  logic [29:0]      acc_word;
  logic [29:0]      acc_word_off;
  logic [31:0]      acc_data;
  logic [3:0]       acc_mask;
  logic             acc_wr;
  logic             acc_in_range;
  logic [IDX_W-1:0] arr_idx;
  logic [3:0]       arr_we;
  logic             arr_re;
  logic [31:0]      arr_rdata;

  assign accept     = (state == IDLE) && req;
  assign enter_resp = (accept && NO_WAIT) || ((state == WAIT) && (cnt == 4'd1));

  // With no wait states the array access happens on the accept edge, so use the live inputs.
  always_comb begin
    acc_word = addr_q[31:2];
    acc_data = wdata_q;
    acc_mask = mask_q;
    acc_wr   = wr_q;
    if (state == IDLE) begin
      acc_word = addr[31:2];
      acc_data = wr_data;
      acc_mask = wr_mask;
      acc_wr   = wr_en;
    end
  end

  // Addresses below the base wrap to a large offset, so one upper-bits test covers both bounds.
  assign acc_word_off = acc_word - ADDR_BASE[31:2];
  assign acc_in_range = (acc_word_off[29:IDX_W] == '0);
  assign arr_idx      = acc_word_off[IDX_W-1:0];
  assign arr_we       = (enter_resp && acc_wr && acc_in_range) ? acc_mask : 4'b0000;
  assign arr_re       = enter_resp && !acc_wr && acc_in_range;

  rv32i_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .idx  (arr_idx),
    .we   (arr_we),
    .wdata(acc_data),
    .re   (arr_re),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      stall   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wr_data;
            mask_q  <= wr_mask;
            wr_q    <= wr_en;
            stall   <= 1'b1;
            if (NO_WAIT) begin
              state <= RESP;
              ack   <= 1'b1;
              err   <= !acc_in_range;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            ack   <= 1'b1;
            err   <= !acc_in_range;
          end
        end
        RESP: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          stall <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          stall <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data = (ack && !wr_q && !err) ? lane_align(arr_rdata, addr_q[1:0]) : 32'h0;

endmodule
